data_mem_controller: RTL and testbench
======================================

# data_mem_controller

Shared data-memory arbiter between the per-thread load/store units of the compute cores and the single-ported external data memory. It accepts NUM_CONSUMERS independent read/write request channels, grants one at a time in round-robin order, forwards the request to memory, and relays the response back. It sits directly downstream of the compute cores' data_mem_* buses.

## Interface
- DATA_MEM_ADDR_BITS, 8: data memory address width
- DATA_MEM_DATA_BITS, 8: data memory data width
- NUM_CONSUMERS, 4: number of LSU request channels (total threads across all cores)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  input  [NUM_CONSUMERS-1:0][DATA_MEM_ADDR_BITS-1:0]  read addresses
- consumer_read_ready  output  NUM_CONSUMERS  one-cycle read completion pulse
- consumer_read_data  output  [NUM_CONSUMERS-1:0][DATA_MEM_DATA_BITS-1:0]  read data, held until next read to that consumer
- consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  input  [NUM_CONSUMERS-1:0][DATA_MEM_ADDR_BITS-1:0]  write addresses
- consumer_write_data  input  [NUM_CONSUMERS-1:0][DATA_MEM_DATA_BITS-1:0]  write data
- consumer_write_ready  output  NUM_CONSUMERS  one-cycle write completion pulse
- mem_read_valid  output  1  memory read request
- mem_read_address  output  DATA_MEM_ADDR_BITS  memory read address
- mem_read_ready  input  1  memory read done; mem_read_data valid this cycle
- mem_read_data  input  DATA_MEM_DATA_BITS  memory read data
- mem_write_valid  output  1  memory write request
- mem_write_address  output  DATA_MEM_ADDR_BITS  memory write address
- mem_write_data  output  DATA_MEM_DATA_BITS  memory write data
- mem_write_ready  input  1  memory write done
- read_count  output  16  completed reads (see Configuration)
- write_count  output  16  completed writes (see Configuration)

## Operation
- States: IDLE, READ_WAIT, WRITE_WAIT, RELEASE. Registers: state, grant index, rr pointer, all outputs.
- IDLE: scan consumers starting at rr pointer, wrapping modulo NUM_CONSUMERS; first with read_valid or write_valid wins. Read beats write on the same consumer. On grant: latch index, drive mem_read_valid/address (→READ_WAIT) or mem_write_valid/address/data (→WRITE_WAIT); rr pointer := grant+1 (wraps to 0 past NUM_CONSUMERS-1).
- READ_WAIT: hold mem request stable until mem_read_ready=1; then deassert mem_read_valid, register mem_read_data into consumer_read_data[grant], pulse consumer_read_ready[grant] for one cycle, →RELEASE.
- WRITE_WAIT: same with mem_write_ready, pulsing consumer_write_ready[grant], →RELEASE.
- RELEASE: wait until both valids of the granted consumer are 0, then →IDLE. Prevents re-serving a stale request.
- Other consumers' requests wait; requests are never dropped or reordered per consumer.
- Reset (async, low): state=IDLE, rr pointer=0, every output (mem valids/addresses/data, consumer ready/data, counters) =0 immediately; in-flight memory transaction abandoned.

## Timing
- Grant decided in IDLE cycle T; mem_*_valid high from T+1.
- mem_*_ready seen in cycle M: consumer_*_ready high exactly in cycle M+1, data valid from M+1.
- Minimum request-to-ready latency: 2 cycles (memory ready in the same cycle as valid).
- Consumer must drop valid after seeing ready; controller returns to IDLE the cycle after both valids observed low; next grant earliest the following cycle.
- mem_read_valid and mem_write_valid never high simultaneously; at most one consumer ready bit high per cycle.
- mem_*_ready while no request outstanding is ignored.

## Configuration
- DMC_PERF_COUNTERS_EN defined: read_count/write_count increment by 1 on each consumer_read_ready/consumer_write_ready pulse, saturating at 16'hFFFF, cleared by reset.
- Not defined: counter logic is absent; read_count and write_count are constant 0.

## Test plan
- Single read: consumer 2 reads addr 0x10, memory returns 0xA5 with 3-cycle latency → mem_read_address=0x10, consumer_read_ready[2] one-cycle pulse, consumer_read_data[2]=0xA5.
- Single write: consumer 0 writes 0x3C to 0x20 → mem_write_valid with addr 0x20/data 0x3C, consumer_write_ready[0] pulse, no read activity.
- Round robin: all 4 consumers read simultaneously from reset → grant order 0,1,2,3; request again → 0,1,2,3; no consumer served twice before others.
- Read/write same consumer: consumer 1 asserts both → read served first, then write after RELEASE/IDLE.
- Reset mid-READ_WAIT: deassert reset low while mem_read_valid=1 → all outputs 0 at once; after release, pending request re-granted from consumer 0.
- With DMC_PERF_COUNTERS_EN: 5 reads, 3 writes → read_count=5, write_count=3; without macro both stay 0.

Source files
------------

// File: rtl/data_mem_controller.sv
// Round-robin arbiter sharing one single-ported data memory among NUM_CONSUMERS load/store channels.
// Optional completion counters are enabled with the DMC_PERF_COUNTERS_EN macro.
module data_mem_controller #(
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8,
  parameter int NUM_CONSUMERS      = 4
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [NUM_CONSUMERS-1:0]                           consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][DATA_MEM_ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                           consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_MEM_DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                           consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][DATA_MEM_ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_MEM_DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                           consumer_write_ready,
  output logic                                               mem_read_valid,
  output logic [DATA_MEM_ADDR_BITS-1:0]                      mem_read_address,
  input  logic                                               mem_read_ready,
  input  logic [DATA_MEM_DATA_BITS-1:0]                      mem_read_data,
  output logic                                               mem_write_valid,
  output logic [DATA_MEM_ADDR_BITS-1:0]                      mem_write_address,
  output logic [DATA_MEM_DATA_BITS-1:0]                      mem_write_data,
  input  logic                                               mem_write_ready,
  output logic [15:0]                                        read_count,
  output logic [15:0]                                        write_count
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] grant, rr_ptr, rr_next;
  logic [IDX_W-1:0] cand, scan_idx;
  logic             scan_found, scan_is_read;
  logic             launch_read, launch_write, finish_read, finish_write;

  // First requester at or after rr_ptr wins; a read outranks a write on the same channel.
  always_comb begin
    cand         = '0;
    scan_idx     = '0;
    scan_found   = 1'b0;
    scan_is_read = 1'b0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_CONSUMERS);
      if (!scan_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
        scan_found   = 1'b1;
        scan_idx     = cand;
        scan_is_read = consumer_read_valid[cand];
      end
    end
    rr_next = (int'(scan_idx) == NUM_CONSUMERS - 1) ? '0 : scan_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    launch_read  = 1'b0;
    launch_write = 1'b0;
    finish_read  = 1'b0;
    finish_write = 1'b0;
    case (state)
      IDLE: begin
        if (scan_found) begin
          launch_read  = scan_is_read;
          launch_write = !scan_is_read;
          state_next   = scan_is_read ? READ_WAIT : WRITE_WAIT;
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          finish_read = 1'b1;
          state_next  = RELEASE;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          finish_write = 1'b1;
          state_next   = RELEASE;
        end
      end
      RELEASE: begin
        // Hold off until the served channel has withdrawn both requests.
        if (!consumer_read_valid[grant] && !consumer_write_valid[grant])
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant                <= '0;
      rr_ptr               <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
    end else begin
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      if (launch_read) begin
        grant            <= scan_idx;
        rr_ptr           <= rr_next;
        mem_read_valid   <= 1'b1;
        mem_read_address <= consumer_read_address[scan_idx];
      end
      if (launch_write) begin
        grant             <= scan_idx;
        rr_ptr            <= rr_next;
        mem_write_valid   <= 1'b1;
        mem_write_address <= consumer_write_address[scan_idx];
        mem_write_data    <= consumer_write_data[scan_idx];
      end
      if (finish_read) begin
        mem_read_valid             <= 1'b0;
        consumer_read_data[grant]  <= mem_read_data;
        consumer_read_ready[grant] <= 1'b1;
      end
      if (finish_write) begin
        mem_write_valid             <= 1'b0;
        consumer_write_ready[grant] <= 1'b1;
      end
    end
  end

`ifdef DMC_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (|consumer_read_ready && read_count != 16'hFFFF)
        read_count <= read_count + 16'd1;
      if (|consumer_write_ready && write_count != 16'hFFFF)
        write_count <= write_count + 16'd1;
    end
  end
`else
  assign read_count  = '0;
  assign write_count = '0;
`endif

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller: the bench plays both the consumers and the memory.
module tb_data_mem_controller;

  logic             clk;
  logic             reset;
  logic [3:0]       rv, wv;
  logic [3:0][7:0]  ra, wa, wd;
  logic [3:0]       consumer_read_ready, consumer_write_ready;
  logic [3:0][7:0]  consumer_read_data;
  logic             mem_read_valid, mem_write_valid;
  logic [7:0]       mem_read_address, mem_write_address, mem_write_data;
  logic             mrr, mwr;
  logic [7:0]       mrd;
  logic [15:0]      read_count, write_count;

  int errors = 0;
  int checks = 0;
  int exp_reads = 0;
  int exp_writes = 0;

  data_mem_controller #(
    .DATA_MEM_ADDR_BITS(8),
    .DATA_MEM_DATA_BITS(8),
    .NUM_CONSUMERS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .consumer_read_valid(rv),
    .consumer_read_address(ra),
    .consumer_read_ready(consumer_read_ready),
    .consumer_read_data(consumer_read_data),
    .consumer_write_valid(wv),
    .consumer_write_address(wa),
    .consumer_write_data(wd),
    .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mrr),
    .mem_read_data(mrd),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mwr),
    .read_count(read_count),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mrv"}, 32'(mem_read_valid), 32'd0);
    check({tag, "_mwv"}, 32'(mem_write_valid), 32'd0);
    check({tag, "_mra"}, 32'(mem_read_address), 32'd0);
    check({tag, "_mwa"}, 32'(mem_write_address), 32'd0);
    check({tag, "_mwd"}, 32'(mem_write_data), 32'd0);
    check({tag, "_crr"}, 32'(consumer_read_ready), 32'd0);
    check({tag, "_cwr"}, 32'(consumer_write_ready), 32'd0);
    check({tag, "_crd"}, 32'(consumer_read_data), 32'd0);
    check({tag, "_rcnt"}, 32'(read_count), 32'd0);
    check({tag, "_wcnt"}, 32'(write_count), 32'd0);
  endtask

  task automatic wait_rd_valid(input string tag);
    int n = 0;
    while (!mem_read_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rd_grant"}, 32'(mem_read_valid), 32'd1);
  endtask

  // Wait for the read grant, answer it after lat idle cycles, check the completion pulse.
  task automatic serve_read(input int c, input logic [7:0] addr, input logic [7:0] data,
                            input int lat);
    wait_rd_valid("serve");
    check("rd_addr", 32'(mem_read_address), 32'(addr));
    check("rd_excl", 32'(mem_write_valid), 32'd0);
    repeat (lat) begin
      @(negedge clk);
      check("rd_hold_ready", 32'(consumer_read_ready), 32'd0);
      check("rd_hold_addr", 32'(mem_read_address), 32'(addr));
    end
    mrr = 1'b1;
    mrd = data;
    @(negedge clk);
    mrr = 1'b0;
    check("rd_ready", 32'(consumer_read_ready), 32'(1 << c));
    check("rd_data", 32'(consumer_read_data[c]), 32'(data));
    check("rd_valid_drop", 32'(mem_read_valid), 32'd0);
    rv[c] = 1'b0;
    exp_reads++;
  endtask

  task automatic serve_write(input int c, input logic [7:0] addr, input logic [7:0] data,
                             input int lat);
    int n = 0;
    while (!mem_write_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_grant", 32'(mem_write_valid), 32'd1);
    check("wr_addr", 32'(mem_write_address), 32'(addr));
    check("wr_data", 32'(mem_write_data), 32'(data));
    check("wr_excl", 32'(mem_read_valid), 32'd0);
    repeat (lat) begin
      @(negedge clk);
      check("wr_hold_ready", 32'(consumer_write_ready), 32'd0);
    end
    mwr = 1'b1;
    @(negedge clk);
    mwr = 1'b0;
    check("wr_ready", 32'(consumer_write_ready), 32'(1 << c));
    check("wr_no_rd_ready", 32'(consumer_read_ready), 32'd0);
    check("wr_valid_drop", 32'(mem_write_valid), 32'd0);
    wv[c] = 1'b0;
    exp_writes++;
  endtask

  initial begin
    reset = 1'b0;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    mrr = 1'b0; mwr = 1'b0; mrd = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Stray memory ready with nothing outstanding
    mrr = 1'b1; mwr = 1'b1; mrd = 8'hEE;
    @(negedge clk);
    mrr = 1'b0; mwr = 1'b0;
    @(negedge clk);
    check("stray_rd_ready", 32'(consumer_read_ready), 32'd0);
    check("stray_wr_ready", 32'(consumer_write_ready), 32'd0);
    check("stray_rd_data", 32'(consumer_read_data), 32'd0);

    // Single read, consumer 2
    rv[2] = 1'b1; ra[2] = 8'h10;
    serve_read(2, 8'h10, 8'hA5, 2);
    @(negedge clk);
    check("rd_pulse_once", 32'(consumer_read_ready), 32'd0);
    check("rd_data_held", 32'(consumer_read_data[2]), 32'hA5);

    // Single write, consumer 0
    wv[0] = 1'b1; wa[0] = 8'h20; wd[0] = 8'h3C;
    serve_write(0, 8'h20, 8'h3C, 0);
    @(negedge clk);
    check("wr_pulse_once", 32'(consumer_write_ready), 32'd0);
    check("wr_no_mrv", 32'(mem_read_valid), 32'd0);

    // Read and write together on consumer 1: read first, write held back while still asserted
    rv[1] = 1'b1; wv[1] = 1'b1; ra[1] = 8'h31; wa[1] = 8'h32; wd[1] = 8'h33;
    serve_read(1, 8'h31, 8'h9E, 0);
    repeat (3) begin
      @(negedge clk);
      check("release_hold", 32'(mem_write_valid), 32'd0);
    end
    wv[1] = 1'b0;
    @(negedge clk);
    wv[1] = 1'b1;
    serve_write(1, 8'h32, 8'h33, 1);
    @(negedge clk);

    // Round robin from reset, two rounds
    reset = 1'b0;
    #1;
    check_zero("rst_pulse");
    exp_reads = 0; exp_writes = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        rv[i] = 1'b1;
        ra[i] = 8'(8'h40 + i);
      end
      for (int i = 0; i < 4; i++)
        serve_read(i, 8'(8'h40 + i), 8'(8'h50 + 4 * r + i), 0);
      @(negedge clk);
    end

    // Reset while consumer 1's read is outstanding; pointer would otherwise favour 3
    rv[1] = 1'b1; ra[1] = 8'h71;
    wait_rd_valid("mid");
    check("mid_addr", 32'(mem_read_address), 32'h71);
    rv[0] = 1'b1; ra[0] = 8'h70;
    rv[3] = 1'b1; ra[3] = 8'h73;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("rst_mid");
    exp_reads = 0; exp_writes = 0;
    @(negedge clk);
    reset = 1'b1;
    serve_read(0, 8'h70, 8'h11, 0);
    serve_read(1, 8'h71, 8'h22, 1);
    serve_read(3, 8'h73, 8'h33, 0);
    @(negedge clk);

    // Fill out 5 reads and 3 writes since the last reset
    for (int k = 0; k < 2; k++) begin
      rv[2] = 1'b1; ra[2] = 8'(8'h80 + k);
      serve_read(2, 8'(8'h80 + k), 8'(8'hC0 + k), 0);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      wv[k] = 1'b1; wa[k] = 8'(8'h90 + k); wd[k] = 8'(8'hD0 + k);
      serve_write(k, 8'(8'h90 + k), 8'(8'hD0 + k), 0);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
`ifdef DMC_PERF_COUNTERS_EN
    check("read_count", 32'(read_count), 32'(exp_reads));
    check("write_count", 32'(write_count), 32'(exp_writes));
`else
    check("read_count", 32'(read_count), 32'd0);
    check("write_count", 32'(write_count), 32'd0);
`endif
    check("end_idle_mrv", 32'(mem_read_valid), 32'd0);
    check("end_idle_mwv", 32'(mem_write_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
